// File: rtl/dma_uart_tx_pkg.sv
// dma_uart_pkg: shared definitions for the DMA-mapped UART transmitter.
//   - command op encodings and the position of the command toggle bit
//   - status word bit positions and a helper that packs the status word
//   - transmit FSM state type
package dma_uart_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;

    localparam int CMD_T = 31;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_ACK     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Builds the CPU-visible status word; unlisted bits read as zero.
    function automatic logic [31:0] pack_status(input logic       busy,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [3:0] count,
                                                input logic       ack);
        logic [31:0] s;
        s                  = '0;
        s[ST_BUSY]         = busy;
        s[ST_FULL]         = full;
        s[ST_OVF]          = ovf;
        s[ST_CNT_LSB +: 4] = count;
        s[ST_ACK]          = ack;
        return s;
    endfunction

endpackage

// File: rtl/dma_uart_tx_if.sv
// dma_uart_tx_if: bundle of the memory-stage DMA register lines and the
// serial-side outputs of the transmitter.
//   i_dma_cmd    command word (DMA register 0)
//   i_dma_data   data word (DMA register 1), low byte used
//   o_dma_status status word read back by the CPU at address 0
//   o_tx         serial line, idles high
//   o_busy       FIFO non-empty or frame in flight
// master = memory stage / bench side, slave = transmitter side.
interface dma_uart_tx_if;
    logic [31:0] i_dma_cmd;
    logic [31:0] i_dma_data;
    logic [31:0] o_dma_status;
    logic        o_tx;
    logic        o_busy;

    modport master (
        output i_dma_cmd,
        output i_dma_data,
        input  o_dma_status,
        input  o_tx,
        input  o_busy
    );

    modport slave (
        input  i_dma_cmd,
        input  i_dma_data,
        output o_dma_status,
        output o_tx,
        output o_busy
    );
endinterface

// File: rtl/dma_uart_tx_sync_fifo.sv
// sync_fifo: small single-clock byte FIFO.
//   clk, rst     clock and synchronous active-high reset
//   push, din    enqueue request and data
//   pop          dequeue request (ignored when empty)
//   flush        discard all entries (wins over a same-cycle push)
//   head         entry at the read pointer, valid when count != 0
//   count, full  occupancy (4 bits) and count == DEPTH
// A push while full is still accepted when a pop happens in the same cycle,
// because the popped slot is freed at the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [3:0]       count,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [3:0]       count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == 4'(DEPTH));
    assign pop_ok  = pop && (count_reg != 4'd0);
    assign push_ok = push && (!full || pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 4'd0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 4'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 4'd1;
                2'b01:   count_reg <= count_reg - 4'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset; an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/dma_uart_tx.sv
// dma_uart_tx: memory-mapped 8N1 UART transmitter behind the DMA registers.
//   clk, rst  clock and synchronous active-high reset
//   bus       dma_uart_tx_if slave: command/data words in, status word,
//             serial line and busy flag out
// A command executes once, in the cycle where the command toggle bit differs
// from the acknowledged toggle ack_t; ack_t then follows the toggle.
module dma_uart_tx
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input logic         clk,
    input logic         rst,
    dma_uart_tx_if.slave bus
);
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic        ack_t_reg;
    logic        ovf_reg;
    logic        cmd_exec;
    logic [1:0]  cmd_op;
    logic        cmd_push;
    logic        cmd_flush;

    logic [7:0]  fifo_head;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_pop;

    tx_state_e   state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  sh_reg, sh_next;
    logic        tx_bit;
    logic        busy;

    // Only the toggle, op field and data byte carry meaning.
    logic        unused_bits;
    assign unused_bits = ^{bus.i_dma_cmd[30:2], bus.i_dma_data[31:8]};

    assign cmd_exec  = (bus.i_dma_cmd[CMD_T] != ack_t_reg);
    assign cmd_op    = bus.i_dma_cmd[1:0];
    assign cmd_push  = cmd_exec && (cmd_op == OP_PUSH);
    assign cmd_flush = cmd_exec && (cmd_op == OP_FLUSH);

    // The head is popped straight into the shift register from IDLE.
    assign fifo_pop  = (state_reg == IDLE) && (fifo_count != 4'd0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .pop   (fifo_pop),
        .flush (cmd_flush),
        .din   (bus.i_dma_data[7:0]),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    // ack_t simply tracks the toggle: once equal, a held word is inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_t_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            ack_t_reg <= bus.i_dma_cmd[CMD_T];
            if (cmd_flush) begin
                ovf_reg <= 1'b0;
            end else if (cmd_push && fifo_full && !fifo_pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            idx_reg   <= 3'd0;
            sh_reg    <= 8'd0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            idx_reg   <= idx_next;
            sh_reg    <= sh_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        idx_next   = idx_reg;
        sh_next    = sh_reg;
        case (state_reg)
            IDLE: begin
                if (fifo_pop) begin
                    sh_next    = fifo_head;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    idx_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        case (state_reg)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = sh_reg[idx_reg];
            default: tx_bit = 1'b1;
        endcase
    end

    assign busy             = (state_reg != IDLE) || (fifo_count != 4'd0);
    assign bus.o_tx         = tx_bit;
    assign bus.o_busy       = busy;
    assign bus.o_dma_status = pack_status(busy, fifo_full, ovf_reg, fifo_count, ack_t_reg);

endmodule

// File: tb/tb_dma_uart_tx.sv
// tb_dma_uart_tx: self-checking bench for dma_uart_tx (16 clocks/bit, 4-deep FIFO).
// A queue-based reference model predicts status, busy and the serial line
// every cycle; a line decoder recovers transmitted bytes for the scenario checks.
module tb_dma_uart_tx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;

    dma_uart_tx_if bus();

    dma_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: queue of waiting bytes, byte on the wire and the
    // number of frame cycles still to go (0 = line idle).
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic       m_ack;
    logic       m_ovf;
    int         m_left;
    logic [7:0] m_cur;

    // Line decoder state.
    logic [7:0] rx_q[$];
    int         rx_starts[$];
    bit         rx_active = 1'b0;
    int         rx_t;
    logic [7:0] rx_byte;

    logic [31:0] cur_cmd = 32'h0;

    typedef struct {
        logic [31:0] cmd;
        logic [7:0]  data;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        logic        busy;
        busy        = (m_left != 0) || (m_q.size() != 0);
        s           = 32'h0;
        s[0]        = busy;
        s[1]        = (m_q.size() == DEPTH);
        s[2]        = m_ovf;
        s[7:4]      = 4'(m_q.size());
        s[8]        = m_ack;
        return s;
    endfunction

    // Bit slot within the frame: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic m_tx();
        int pos;
        if (m_left == 0) return 1'b1;
        pos = (FRAME - m_left) / CPB;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return m_cur[pos-1];
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] cmd, input logic [7:0] data);
        bit pop;
        if (r) begin
            m_q.delete();
            m_ack  = 1'b0;
            m_ovf  = 1'b0;
            m_left = 0;
            m_cur  = 8'h00;
        end else begin
            pop = (m_left == 0) && (m_q.size() > 0);
            if (pop) begin
                m_cur  = m_q.pop_front();
                m_sent.push_back(m_cur);
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (cmd[31] != m_ack) begin
                if (cmd[1:0] == 2'b01) begin
                    if (m_q.size() < DEPTH) m_q.push_back(data);
                    else m_ovf = 1'b1;
                end else if (cmd[1:0] == 2'b10) begin
                    m_q.delete();
                    m_ovf = 1'b0;
                end
            end
            m_ack = cmd[31];
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input logic [31:0] cmd, input logic [7:0] data, input logic r);
        int bi;
        cur_cmd        = cmd;
        rst            = r;
        bus.i_dma_cmd  = cmd;
        bus.i_dma_data = {24'($urandom), data};
        model_step(r, cmd, data);
        @(posedge clk);
        #1;
        cyc++;
        check("status", bus.o_dma_status, m_status());
        check("busy", 32'(bus.o_busy), 32'((m_left != 0) || (m_q.size() != 0)));
        check("tx", 32'(bus.o_tx), 32'(m_tx()));
        if (r) begin
            rx_active = 1'b0;
        end else if (rx_active) begin
            rx_t++;
            if (rx_t >= CPB + CPB/2 && rx_t < 9*CPB && ((rx_t - CPB/2) % CPB) == 0) begin
                bi = (rx_t - CPB/2) / CPB - 1;
                rx_byte[bi] = bus.o_tx;
            end
            if (rx_t == 9*CPB + CPB/2) begin
                check("stop_bit", 32'(bus.o_tx), 32'h1);
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end else if (bus.o_tx == 1'b0) begin
            rx_active = 1'b1;
            rx_t      = 0;
            rx_starts.push_back(cyc);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < limit) begin
            cycle(cur_cmd, 8'h00, 1'b0);
            n++;
        end
        check("idle_timeout", 32'(bus.o_busy), 32'h0);
    endtask

    // Expected bytes packed first-at-LSB.
    task automatic expect_rx(input string name, input int n, input logic [63:0] bytes);
        check({name, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check(name, 32'(rx_q[i]), 32'(bytes[8*i +: 8]));
        end
        rx_q.delete();
        rx_starts.delete();
    endtask

    initial begin
        logic [31:0] rc;
        int          gap;
        int          sel;

        vecs[0] = '{32'h8000_0001, 8'hA5, 32'h111};
        vecs[1] = '{32'h8000_0001, 8'h00, 32'h101};
        vecs[2] = '{32'h0000_0001, 8'h3C, 32'h011};
        vecs[3] = '{32'h8000_0001, 8'h5A, 32'h121};
        vecs[4] = '{32'h0000_0001, 8'h96, 32'h031};
        vecs[5] = '{32'h8000_0001, 8'h0F, 32'h143};
        vecs[6] = '{32'h0000_0001, 8'hEE, 32'h047};
        vecs[7] = '{32'h0000_0000, 8'h00, 32'h047};
        vecs[8] = '{32'h8000_0003, 8'h00, 32'h147};

        // Reset, then a stable zero command must do nothing.
        cycle(32'h0, 8'h00, 1'b1);
        cycle(32'h0, 8'h00, 1'b1);
        check("rst_tx", 32'(bus.o_tx), 32'h1);
        check("rst_status", bus.o_dma_status, 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        repeat (3) cycle(32'h0, 8'h00, 1'b0);
        check("stable_cmd", bus.o_dma_status, 32'h0);

        // Single byte followed by pushes until overflow.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].cmd, vecs[i].data, 1'b0);
            check($sformatf("vec%0d", i), bus.o_dma_status, vecs[i].exp_status);
        end
        repeat (153) cycle(32'h8000_0003, 8'h00, 1'b0);
        check("pre_pop", bus.o_dma_status, 32'h147);
        // Push lands in the IDLE cycle that pops a full FIFO.
        cycle(32'h0000_0001, 8'h77, 1'b0);
        check("push_with_pop", bus.o_dma_status, 32'h047);
        wait_idle(2000);
        expect_rx("ovf_rx", 6, 64'h0000_770F_965A_3CA5);
        check("ovf_idle", bus.o_dma_status, 32'h004);

        // FLUSH during the first byte's data bits.
        cycle(32'h8000_0001, 8'h11, 1'b0);
        check("flush_push1", bus.o_dma_status, 32'h115);
        cycle(32'h0000_0001, 8'h22, 1'b0);
        check("flush_push2", bus.o_dma_status, 32'h015);
        cycle(32'h8000_0001, 8'h33, 1'b0);
        check("flush_push3", bus.o_dma_status, 32'h125);
        repeat (40) cycle(32'h8000_0001, 8'h00, 1'b0);
        cycle(32'h0000_0002, 8'h00, 1'b0);
        check("flush", bus.o_dma_status, 32'h001);
        wait_idle(2000);
        expect_rx("flush_rx", 1, 64'h11);
        check("flush_idle", bus.o_dma_status, 32'h000);

        // FLUSH in the same cycle as the IDLE pop.
        cycle(32'h8000_0001, 8'h44, 1'b0);
        cycle(32'h0000_0002, 8'h00, 1'b0);
        check("flush_pop", bus.o_dma_status, 32'h001);
        wait_idle(2000);
        expect_rx("flush_pop_rx", 1, 64'h44);

        // Back-to-back frames.
        cycle(32'h8000_0001, 8'h00, 1'b0);
        cycle(32'h0000_0001, 8'hFF, 1'b0);
        wait_idle(2000);
        gap = (rx_starts.size() >= 2) ? rx_starts[1] - rx_starts[0] : -1;
        check("b2b_gap", 32'(gap), 32'(FRAME + 1));
        expect_rx("b2b_rx", 2, 64'hFF00);

        // Reset during data bit 3, then a normal transfer.
        cycle(32'h8000_0001, 8'hC3, 1'b0);
        repeat (71) cycle(32'h8000_0001, 8'h00, 1'b0);
        cycle(32'h0, 8'h00, 1'b1);
        check("rst_mid_tx", 32'(bus.o_tx), 32'h1);
        check("rst_mid_status", bus.o_dma_status, 32'h0);
        rx_q.delete();
        rx_starts.delete();
        cycle(32'h0, 8'h00, 1'b0);
        cycle(32'h8000_0001, 8'h5E, 1'b0);
        check("post_rst_push", bus.o_dma_status, 32'h111);
        wait_idle(2000);
        expect_rx("post_rst_rx", 1, 64'h5E);

        // Randomized command traffic against the model.
        m_sent.delete();
        rc = cur_cmd;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 6)       rc = {~rc[31], 29'($urandom), 2'b01};
                else if (sel == 6) rc = {~rc[31], 29'($urandom), 2'b10};
                else if (sel == 7) rc = {~rc[31], 29'($urandom), 2'b00};
                else if (sel == 8) rc = {~rc[31], 29'($urandom), 2'b11};
                else               rc = {rc[31], 29'($urandom), 2'b01};
            end
            cycle(rc, 8'($urandom), 1'b0);
        end
        wait_idle(3000);
        check("rand_rx_count", 32'(rx_q.size()), 32'(m_sent.size()));
        for (int i = 0; i < m_sent.size(); i++) begin
            if (i < rx_q.size()) check("rand_rx", 32'(rx_q[i]), 32'(m_sent[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
